// File: rtl/makina_pkg.sv
// Shared fetch types and defaults for the 16-bit core.
// Holds widths, the reset PC and the fetch FSM state encoding.
package makina_pkg;

  localparam int ADDR_W_D    = 16;
  localparam int INSTR_W_D   = 16;
  localparam int RAS_DEPTH_D = 4;

  localparam logic [15:0] RESET_PC_D = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry.
// top is the raw newest entry; callers qualify it with empty.
module fetch_ras
  import makina_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     sp;
  logic [PW:0]       cnt;
  logic [PW-1:0]     sp_top;

  assign sp_top = sp - 1'b1;
  assign empty  = (cnt == '0);
  assign top    = mem[sp_top];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && pop && !empty) begin
      // pop consumed the old top, so the push lands in its slot
      mem[sp_top] <= push_data;
    end else if (push) begin
      mem[sp] <= push_data;
      sp      <= sp + 1'b1;
      if (cnt != FULL) begin
        cnt <= cnt + 1'b1;
      end
    end else if (pop && !empty) begin
      sp  <= sp_top;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC owner, imem requester, decode handshake, redirects.
// Define FETCH_RAS_EN to add call_push/ret_pop and the return stack.
module fetch_sequencer
  import makina_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_D,
  parameter int INSTR_W   = INSTR_W_D,
  parameter int RAS_DEPTH = RAS_DEPTH_D,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_D)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               br_valid,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               halt,
`ifdef FETCH_RAS_EN
  input  logic               call_push,
  input  logic               ret_pop,
`endif
  output logic               halted
);

  localparam bit RAS_POW2 =
    ((RAS_DEPTH & (RAS_DEPTH - 1)) == 0);

  fetch_state_e      state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic              squash, squash_nx;
  logic              latch;
  logic              br_take;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  assign br_take = br_valid & br_taken;

`ifdef FETCH_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic [ADDR_W-1:0] ras_top;

  // a taken branch outranks a return
  assign ras_push = br_take & call_push;
  assign ras_pop  = ret_pop & ~br_take;

  fetch_ras #(
    .DEPTH  (RAS_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (instr_pc + 1'b1),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign redirect    = br_take | ras_pop;
  assign redirect_pc = br_take   ? br_target :
                       ras_empty ? RESET_PC  : ras_top;
`else
  assign redirect    = br_take;
  assign redirect_pc = br_target;
`endif

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    squash_nx = squash;
    latch     = 1'b0;
    unique case (state)
      ST_IDLE: state_nx = halt ? ST_HALT : ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          state_nx  = ST_WAIT;
          squash_nx = redirect;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          if (squash || redirect) begin
            squash_nx = 1'b0;
            state_nx  = ST_REQ;
          end else begin
            latch    = 1'b1;
            state_nx = ST_HOLD;
          end
        end else if (redirect) begin
          squash_nx = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_nx = ST_REQ;
        end else if (instr_ready) begin
          pc_nx    = pc + 1'b1;
          state_nx = halt ? ST_HALT : ST_REQ;
        end
      end
      ST_HALT: begin
        if (!halt) begin
          state_nx = ST_REQ;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (redirect) begin
      pc_nx = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      squash   <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      squash <= squash_nx;
      if (latch) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_HOLD);
  assign halted      = (state == ST_HALT);

  // read data may only arrive while a request is outstanding
  always @(posedge clk) begin
    if (!rst) begin
      assert (RAS_POW2 && (!imem_valid || state == ST_WAIT));
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then random
// traffic; expected PCs come from a simple next-PC model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        halt = 1'b0;
  logic        halted;
`ifdef FETCH_RAS_EN
  logic        call_push = 1'b0;
  logic        ret_pop = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt        (halt),
`ifdef FETCH_RAS_EN
    .call_push   (call_push),
    .ret_pop     (ret_pop),
`endif
    .halted      (halted)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mem_lat = 0;
  int ack_pct = 100;

  logic [15:0] exp_q[$];
  logic [15:0] ack_log[$];
  logic [15:0] hs_pc[$];
  int          hs_cyc[$];

  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = '0;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory: log accepted requests, return data mem_lat cycles later
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else if (imem_req && imem_ack) begin
      ack_log.push_back(imem_addr);
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = mem_lat;
    end
  end

  always @(posedge clk) begin
    #1;
    imem_ack   = 1'b0;
    imem_valid = 1'b0;
    if (!rst) begin
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_f(pend_addr);
          pend       = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (imem_req && $urandom_range(99) < ack_pct)
        imem_ack = 1'b1;
    end
  end

  // monitor: every accepted instruction must be the model's next PC
  always @(negedge clk) begin
    logic        redir;
    logic [15:0] e;
    if (!rst) begin
      redir = br_valid && br_taken;
`ifdef FETCH_RAS_EN
      redir = redir || ret_pop;
`endif
      if (instr_valid && instr_ready && !redir) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 32'(instr_pc), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(e));
          check("instr", 32'(instr), 32'(mem_f(e)));
          exp_q.push_back(e + 16'd1);
        end
        hs_pc.push_back(instr_pc);
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [15:0] t);
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = t;
    exp_q.delete();
    exp_q.push_back(t);
    step();
    br_valid = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic wait_acks(input int k, input string nm);
    int n = 0;
    while (ack_log.size() < k && n < 300) begin step(); n++; end
    if (ack_log.size() < k) timeout(nm);
  endtask

  task automatic wait_hs(input int k, input string nm);
    int n = 0;
    while (hs_pc.size() < k && n < 300) begin step(); n++; end
    if (hs_pc.size() < k) timeout(nm);
  endtask

  task automatic wait_hold(input logic [15:0] p, input bit any,
                           input string nm);
    int n = 0;
    while (!(instr_valid && (any || instr_pc == p)) && n < 300) begin
      step();
      n++;
    end
    if (!instr_valid) timeout(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    int bad;
    rst = 1'b0;
    #1 rst = 1'b1;
    exp_q.push_back(16'h0000);
    step();
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    instr_ready = 1'b1;
    step();
    rst = 1'b0;

    // 1: sequential fetch, 3 cycles per instruction
    wait_hs(3, "t1_hs");
    if (hs_pc.size() >= 3 && ack_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t1_ack_addr", 32'(ack_log[i]), i);
        check("t1_pc", 32'(hs_pc[i]), i);
      end
      check("t1_gap1", hs_cyc[1] - hs_cyc[0], 3);
      check("t1_gap2", hs_cyc[2] - hs_cyc[1], 3);
    end

    // 2: branch in HOLD at pc 5 with a simultaneous ready
    wait_hold(16'h0005, 1'b0, "t2_hold5");
    ack_log.delete();
    hs_pc.delete();
    redirect_to(16'h0040);
    wait_acks(1, "t2_ack");
    if (ack_log.size() >= 1)
      check("t2_next_addr", 32'(ack_log[0]), 32'h40);
    wait_hs(1, "t2_hs");
    if (hs_pc.size() >= 1)
      check("t2_next_pc", 32'(hs_pc[0]), 32'h40);

    // 3: branch while waiting on slow memory
    mem_lat = 3;
    ack_log.delete();
    wait_acks(1, "t3_ack");
    hs_pc.delete();
    redirect_to(16'h0100);
    wait_hs(1, "t3_hs");
    if (hs_pc.size() >= 1)
      check("t3_pc", 32'(hs_pc[0]), 32'h100);

    // 4: pc wraps from FFFF to 0
    hs_pc.delete();
    redirect_to(16'hFFFF);
    wait_hs(1, "t4_hs");
    ack_log.delete();
    if (hs_pc.size() >= 1)
      check("t4_pc", 32'(hs_pc[0]), 32'hFFFF);
    wait_acks(1, "t4_ack");
    if (ack_log.size() >= 1)
      check("t4_wrap_addr", 32'(ack_log[0]), 0);
    wait_hs(2, "t4_hs2");

    // 5: halt during WAIT
    ack_log.delete();
    wait_acks(1, "t5_ack");
    halt = 1'b1;
    hs_pc.delete();
    wait_hs(1, "t5_hs");
    p = (hs_pc.size() >= 1) ? hs_pc[0] : 16'h0;
    if (ack_log.size() >= 1)
      check("t5_pc", 32'(p), 32'(ack_log[0]));
    check("t5_halted", 32'(halted), 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req || !halted) bad++;
      step();
    end
    check("t5_stays_halted", bad, 0);
    check("t5_no_delivery", hs_pc.size(), 1);
    halt = 1'b0;
    step();
    check("t5_resumed", 32'(halted), 0);
    wait_hs(2, "t5_hs2");
    if (hs_pc.size() >= 2)
      check("t5_resume_pc", 32'(hs_pc[1]), 32'(p + 16'd1));

`ifdef FETCH_RAS_EN
    // 6: five calls then five returns on a 4-deep stack
    begin
      logic [15:0] ras[$];
      logic [15:0] t;
      mem_lat = 0;
      for (int i = 0; i < 5; i++) begin
        wait_hold(16'h0, 1'b1, "t6_push_hold");
        ras.push_back(instr_pc + 16'd1);
        if (ras.size() > 4) void'(ras.pop_front());
        call_push = 1'b1;
        redirect_to(16'h0200 + 16'(i * 16));
        call_push = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        wait_hold(16'h0, 1'b1, "t6_pop_hold");
        t = (ras.size() == 0) ? 16'h0000 : ras.pop_back();
        ret_pop = 1'b1;
        exp_q.delete();
        exp_q.push_back(t);
        hs_pc.delete();
        step();
        ret_pop = 1'b0;
        wait_hs(1, "t6_hs");
        if (hs_pc.size() >= 1)
          check("t6_ret_pc", 32'(hs_pc[0]), 32'(t));
      end
    end
`endif

    // random traffic against the next-PC model
    ack_pct = 60;
    hs_pc.delete();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(99));
      instr_ready = ($urandom_range(9) < 7);
      if (i % 50 == 0) mem_lat = int'($urandom_range(3));
      br_valid = 1'b0;
      br_taken = 1'b0;
      if (r < 4) begin
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'($urandom);
        exp_q.delete();
        exp_q.push_back(br_target);
      end else if (r < 8) begin
        br_valid  = 1'b1;
        br_target = 16'($urandom);
      end
      step();
    end
    br_valid = 1'b0;
    br_taken = 1'b0;
    check("random_progress", 32'(hs_pc.size() > 50), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
